// File: rtl/pipe_pkg.sv
// Shared pipeline payload layout: field widths, per-boundary payload widths and
// field offsets so every stage packs and unpacks stage registers consistently.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned WORD_W     = 32;

  // IF/ID: {instr, pc}
  localparam int unsigned IFID_PC_LSB    = 0;
  localparam int unsigned IFID_INSTR_LSB = IFID_PC_LSB + WORD_W;
  localparam int unsigned IFID_W         = IFID_INSTR_LSB + WORD_W;

  // ID/EX: {alu_ctrl, rd, imm, rs2_val, rs1_val, pc}
  localparam int unsigned IDEX_PC_LSB   = 0;
  localparam int unsigned IDEX_RS1_LSB  = IDEX_PC_LSB + WORD_W;
  localparam int unsigned IDEX_RS2_LSB  = IDEX_RS1_LSB + WORD_W;
  localparam int unsigned IDEX_IMM_LSB  = IDEX_RS2_LSB + WORD_W;
  localparam int unsigned IDEX_RD_LSB   = IDEX_IMM_LSB + WORD_W;
  localparam int unsigned IDEX_ALU_LSB  = IDEX_RD_LSB + REG_ADDR_W;
  localparam int unsigned IDEX_W        = IDEX_ALU_LSB + ALU_CTRL_W;

  // EX/MEM: {reg_we, mem_re, mem_we, rd, rs2_val, alu_res}
  localparam int unsigned EXMEM_RES_LSB    = 0;
  localparam int unsigned EXMEM_RS2_LSB    = EXMEM_RES_LSB + WORD_W;
  localparam int unsigned EXMEM_RD_LSB     = EXMEM_RS2_LSB + WORD_W;
  localparam int unsigned EXMEM_MEM_WE_LSB = EXMEM_RD_LSB + REG_ADDR_W;
  localparam int unsigned EXMEM_MEM_RE_LSB = EXMEM_MEM_WE_LSB + 1;
  localparam int unsigned EXMEM_REG_WE_LSB = EXMEM_MEM_RE_LSB + 1;
  localparam int unsigned EXMEM_W          = EXMEM_REG_WE_LSB + 1;

  // MEM/WB: {reg_we, rd, wb_data}
  localparam int unsigned MEMWB_DATA_LSB   = 0;
  localparam int unsigned MEMWB_RD_LSB     = MEMWB_DATA_LSB + WORD_W;
  localparam int unsigned MEMWB_REG_WE_LSB = MEMWB_RD_LSB + REG_ADDR_W;
  localparam int unsigned MEMWB_W          = MEMWB_REG_WE_LSB + 1;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready payload channel between pipeline stages.
// A beat transfers on a rising edge where valid and ready are both 1; the
// master holds valid and data stable until that edge, ready may toggle freely.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid storage with its valid flag; clear wins over write and read.
module pipe_skid_buf #(
  parameter int              DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and a
// saturating stall counter. Define PIPE_STAGE_REG_SKID_EN for a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int                CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_stage_reg_if.slave      upstream,
  pipe_stage_reg_if.master     downstream,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 stall_cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              in_xfer;
  logic              load_en;
  logic [DATA_W-1:0] load_data;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_wr;
  logic              skid_rd;

  assign upstream.ready = !skid_valid;
  assign in_xfer        = upstream.valid && !skid_valid;
  // A beat arriving while the main register is blocked parks in the skid entry.
  assign skid_wr        = in_xfer && main_valid && !downstream.ready;
  assign skid_rd        = skid_valid && downstream.ready;
  assign load_en        = skid_rd || (in_xfer && !skid_wr);
  assign load_data      = skid_rd ? skid_data : upstream.data;

  pipe_skid_buf #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (skid_wr),
    .wr_data (upstream.data),
    .rd_en   (skid_rd),
    .valid   (skid_valid),
    .data    (skid_data)
  );
`else
  assign upstream.ready = !main_valid || downstream.ready;
  assign in_xfer        = upstream.valid && upstream.ready;
  assign load_en        = in_xfer;
  assign load_data      = upstream.data;
`endif

  // Flush drops the valid bit only; the stale payload stays visible on out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= RESET_DATA;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (load_en) begin
      main_valid <= 1'b1;
      main_data  <= load_data;
    end else if (downstream.ready) begin
      main_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (main_valid && !downstream.ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign downstream.valid = main_valid;
  assign downstream.data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based occupancy model checked every cycle,
// plus directed literal scenarios. Builds with or without PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;

  localparam int          W       = 32;
  localparam logic [W-1:0] RST_VAL = 32'hCAFE_0001;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         out_ready = 1'b0;
  logic         flush     = 1'b0;
  logic         clr       = 1'b0;
  logic [15:0]  stall_cnt;
  logic [3:0]   stall4;

  pipe_stage_reg_if #(.DATA_W(W)) up_if ();
  pipe_stage_reg_if #(.DATA_W(W)) dn_if ();
  pipe_stage_reg_if #(.DATA_W(W)) up4_if ();
  pipe_stage_reg_if #(.DATA_W(W)) dn4_if ();

  assign up_if.valid  = in_valid;
  assign up_if.data   = in_data;
  assign dn_if.ready  = out_ready;
  assign up4_if.valid = in_valid;
  assign up4_if.data  = in_data;
  assign dn4_if.ready = out_ready;

  pipe_stage_reg #(.DATA_W(W), .RESET_DATA(RST_VAL), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .upstream      (up_if),
    .downstream    (dn_if),
    .flush         (flush),
    .stall_cnt     (stall_cnt),
    .stall_cnt_clr (clr)
  );

  pipe_stage_reg #(.DATA_W(W), .RESET_DATA(RST_VAL), .CNT_W(4)) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .upstream      (up4_if),
    .downstream    (dn4_if),
    .flush         (flush),
    .stall_cnt     (stall4),
    .stall_cnt_clr (clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / reference model: queue of held payloads in FIFO order
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = RST_VAL;
  int           m_c16    = 0;
  int           m_c4     = 0;

  function automatic logic model_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk) begin : model_step
    logic rdy;
    logic ov;
    if (!rst_n) begin
      exp_q.delete();
      last_out = RST_VAL;
      m_c16    = 0;
      m_c4     = 0;
    end else begin
      rdy = model_ready();
      ov  = exp_q.size() != 0;
      if (clr) begin
        m_c16 = 0;
        m_c4  = 0;
      end else if (ov && !out_ready) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c4 < 15) m_c4++;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (ov && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy) exp_q.push_back(in_data);
      end
      if (exp_q.size() != 0) last_out = exp_q[0];
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", dn_if.valid, exp_q.size() != 0);
      check("out_data", dn_if.data, (exp_q.size() != 0) ? exp_q[0] : last_out);
      check("in_ready", up_if.ready, model_ready());
      check("stall_cnt", stall_cnt, m_c16);
      check("out_valid4", dn4_if.valid, exp_q.size() != 0);
      check("in_ready4", up4_if.ready, model_ready());
      check("stall_cnt4", stall4, m_c4);
    end
  end

  // driver tasks
  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input logic cl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    clr       = cl;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin : stim
    logic [W-1:0] seen[$];
    logic [W-1:0] got;
    int           sent;
    int           mode;

    repeat (3) tick();
    rst_n = 1'b1;
    check("rst out_valid", dn_if.valid, 1'b0);
    check("rst out_data", dn_if.data, RST_VAL);
    check("rst stall_cnt", stall_cnt, 16'd0);
    check("rst in_ready", up_if.ready, 1'b1);

    // single beat
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    check("beat valid", dn_if.valid, 1'b1);
    check("beat data", dn_if.data, 32'hDEADBEEF);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("beat gone", dn_if.valid, 1'b0);

    // stall and hold
    drive(1'b1, 32'h1234, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold data", dn_if.data, 32'h1234);
      check("hold valid", dn_if.valid, 1'b1);
`ifdef PIPE_STAGE_REG_SKID_EN
      check("hold in_ready", up_if.ready, 1'b1);
`else
      check("hold in_ready", up_if.ready, 1'b0);
`endif
    end
    check("stall 5", stall_cnt, 16'd5);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stall drained", dn_if.valid, 1'b0);
    check("stall kept", stall_cnt, 16'd5);
    drain();

    // flush
    drive(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
    tick();
`ifdef PIPE_STAGE_REG_SKID_EN
    drive(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
    tick();
    check("skid full", up_if.ready, 1'b0);
`else
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
`endif
    drive(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
    tick();
    check("flush valid", dn_if.valid, 1'b0);
    check("flush data", dn_if.data, 32'hA5);
    check("flush in_ready", up_if.ready, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      tick();
      check("flush stays empty", dn_if.valid, 1'b0);
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    // skid order: 1,2,3 with downstream blocked on the second cycle
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      drive(sent < 3, W'(sent + 1), c != 1, 1'b0, 1'b0);
      #1;
      if (dn_if.valid && out_ready) seen.push_back(dn_if.data);
      if (in_valid && up_if.ready) sent++;
      tick();
    end
    check("skid count", seen.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got = (i < seen.size()) ? seen[i] : '1;
      check("skid order", got, W'(i + 1));
    end
    drain();
`endif

    // saturation
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    check("sat 4bit", stall4, 4'd15);
    check("sat 16bit", stall_cnt, 16'd20);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("clr 4bit", stall4, 4'd0);
    check("clr 16bit", stall_cnt, 16'd0);
    drain();

    // randomized traffic
    mode = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) mode = $urandom_range(0, 2);
      if (i == 400) begin
        rst_n = 1'b0;
        #1;
        check("mid reset valid", dn_if.valid, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, $urandom,
            (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0),
            $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
      tick();
    end

    // reset in the middle of a held transfer
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("async valid", dn_if.valid, 1'b0);
    check("async data", dn_if.data, RST_VAL);
    check("async stall", stall_cnt, 16'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
